// File: rtl/hazard_tracker_pkg.sv
// Shared widths, forwarding-select codes and tnew markers for the hazard tracker.
package hazard_tracker_pkg;

   localparam int TNEW_W = 3;
   localparam int REG_W  = 5;

   // Forwarding source codes, ordered from oldest value (RF) to the stages.
   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   // tnew value used by the stall detector for instructions that produce nothing.
   localparam logic [TNEW_W-1:0] TNEW_NONE = 3'd4;

endpackage

// File: rtl/hazard_tracker_fwd_select.sv
// Priority forwarding select for one read port.
// Stage slot 0 is E, 1 is M and 2 is W; en masks out stages that are not
// downstream of the reading stage. The youngest supplying stage wins.
module hazard_tracker_fwd_select #(
   parameter int TNEW_W = hazard_tracker_pkg::TNEW_W,
   parameter int REG_W  = hazard_tracker_pkg::REG_W
) (
   input  logic [REG_W-1:0]            rd,
   input  logic [2:0][TNEW_W-1:0]      tnew,
   input  logic [2:0][REG_W-1:0]       a3,
   input  logic [2:0]                  rfwr,
   input  logic [2:0]                  en,
   output logic [1:0]                  sel
);
   import hazard_tracker_pkg::*;

   logic [2:0] supply;

   // A stage supplies rd only once its result exists; $0 is never forwarded.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_supply
         assign supply[gi] = en[gi] & rfwr[gi] & (a3[gi] == rd) &
                             (rd != '0) & (tnew[gi] == '0);
      end
   endgenerate

   // Newest supplying stage takes priority; fall back to the register file / pipe value.
   always_comb begin
      sel = FWD_RF;
      if (supply[0])
         sel = FWD_E;
      else if (supply[1])
         sel = FWD_M;
      else if (supply[2])
         sel = FWD_W;
   end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard tracker: carries tnew/A3/RFWR down the E/M/W stages with a saturating
// tnew countdown, drives stall enables and the E bubble, and produces the
// forwarding selects for the D, E and M stage read ports.
module hazard_tracker #(
   parameter int TNEW_W = hazard_tracker_pkg::TNEW_W,
   parameter int REG_W  = hazard_tracker_pkg::REG_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [TNEW_W-1:0] D_tnew,
   input  logic [REG_W-1:0]  D_A3,
   input  logic              D_RFWR,
   input  logic [REG_W-1:0]  D_rs,
   input  logic [REG_W-1:0]  D_rt,
   output logic              pc_en,
   output logic              d_en,
   output logic              e_clr,
   output logic [TNEW_W-1:0] E_tnew,
   output logic [TNEW_W-1:0] M_tnew,
   output logic [TNEW_W-1:0] W_tnew,
   output logic [REG_W-1:0]  E_A3,
   output logic [REG_W-1:0]  M_A3,
   output logic [REG_W-1:0]  W_A3,
   output logic              E_RFWR,
   output logic              M_RFWR,
   output logic              W_RFWR,
   output logic [1:0]        fwd_D_rs,
   output logic [1:0]        fwd_D_rt,
   output logic [1:0]        fwd_E_rs,
   output logic [1:0]        fwd_E_rt,
   output logic              fwd_M_rt,
   output logic [CNT_W-1:0]  stall_cnt
);
   import hazard_tracker_pkg::*;

   // Saturating countdown: a result that already exists stays available.
   function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] x);
      return (x == '0) ? '0 : x - TNEW_W'(1);
   endfunction

   logic [TNEW_W-1:0] e_tnew_reg, m_tnew_reg, w_tnew_reg;
   logic [REG_W-1:0]  e_a3_reg, m_a3_reg, w_a3_reg;
   logic              e_rfwr_reg, m_rfwr_reg, w_rfwr_reg;
   logic [REG_W-1:0]  e_rs_reg, e_rt_reg, m_rt_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;

   logic [2:0][TNEW_W-1:0] stage_tnew;
   logic [2:0][REG_W-1:0]  stage_a3;
   logic [2:0]             stage_rfwr;
   logic [1:0]             fwd_m_rt_sel;

   // Stall control is a direct function of the request, reset or not.
   assign pc_en = ~stall;
   assign d_en  = ~stall;
   assign e_clr = stall;

   // E loads the D instruction or a bubble; M and W always advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_tnew_reg    <= '0;
         e_a3_reg      <= '0;
         e_rfwr_reg    <= 1'b0;
         e_rs_reg      <= '0;
         e_rt_reg      <= '0;
         m_tnew_reg    <= '0;
         m_a3_reg      <= '0;
         m_rfwr_reg    <= 1'b0;
         m_rt_reg      <= '0;
         w_tnew_reg    <= '0;
         w_a3_reg      <= '0;
         w_rfwr_reg    <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         if (stall) begin
            e_tnew_reg    <= '0;
            e_a3_reg      <= '0;
            e_rfwr_reg    <= 1'b0;
            e_rs_reg      <= '0;
            e_rt_reg      <= '0;
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end else begin
            e_tnew_reg <= tnew_dec(D_tnew);
            e_a3_reg   <= D_A3;
            e_rfwr_reg <= D_RFWR;
            e_rs_reg   <= D_rs;
            e_rt_reg   <= D_rt;
         end
         m_tnew_reg <= tnew_dec(e_tnew_reg);
         m_a3_reg   <= e_a3_reg;
         m_rfwr_reg <= e_rfwr_reg;
         m_rt_reg   <= e_rt_reg;
         w_tnew_reg <= tnew_dec(m_tnew_reg);
         w_a3_reg   <= m_a3_reg;
         w_rfwr_reg <= m_rfwr_reg;
      end
   end

   assign E_tnew    = e_tnew_reg;
   assign M_tnew    = m_tnew_reg;
   assign W_tnew    = w_tnew_reg;
   assign E_A3      = e_a3_reg;
   assign M_A3      = m_a3_reg;
   assign W_A3      = w_a3_reg;
   assign E_RFWR    = e_rfwr_reg;
   assign M_RFWR    = m_rfwr_reg;
   assign W_RFWR    = w_rfwr_reg;
   assign stall_cnt = stall_cnt_reg;

   // Slot order matches the select codes: slot 0 = E, 1 = M, 2 = W.
   assign stage_tnew = {w_tnew_reg, m_tnew_reg, e_tnew_reg};
   assign stage_a3   = {w_a3_reg, m_a3_reg, e_a3_reg};
   assign stage_rfwr = {w_rfwr_reg, m_rfwr_reg, e_rfwr_reg};

   hazard_tracker_fwd_select #(.TNEW_W(TNEW_W), .REG_W(REG_W)) u_fwd_d_rs (
      .rd(D_rs), .tnew(stage_tnew), .a3(stage_a3), .rfwr(stage_rfwr),
      .en(3'b111), .sel(fwd_D_rs)
   );

   hazard_tracker_fwd_select #(.TNEW_W(TNEW_W), .REG_W(REG_W)) u_fwd_d_rt (
      .rd(D_rt), .tnew(stage_tnew), .a3(stage_a3), .rfwr(stage_rfwr),
      .en(3'b111), .sel(fwd_D_rt)
   );

   hazard_tracker_fwd_select #(.TNEW_W(TNEW_W), .REG_W(REG_W)) u_fwd_e_rs (
      .rd(e_rs_reg), .tnew(stage_tnew), .a3(stage_a3), .rfwr(stage_rfwr),
      .en(3'b110), .sel(fwd_E_rs)
   );

   hazard_tracker_fwd_select #(.TNEW_W(TNEW_W), .REG_W(REG_W)) u_fwd_e_rt (
      .rd(e_rt_reg), .tnew(stage_tnew), .a3(stage_a3), .rfwr(stage_rfwr),
      .en(3'b110), .sel(fwd_E_rt)
   );

   hazard_tracker_fwd_select #(.TNEW_W(TNEW_W), .REG_W(REG_W)) u_fwd_m_rt (
      .rd(m_rt_reg), .tnew(stage_tnew), .a3(stage_a3), .rfwr(stage_rfwr),
      .en(3'b100), .sel(fwd_m_rt_sel)
   );

   // Only W can feed the M store data, so any non-zero select means W.
   assign fwd_M_rt = (fwd_m_rt_sel == FWD_W);

endmodule

// File: tb/tb_hazard_tracker.sv
// Testbench for hazard_tracker: directed instruction sequences, a stage-list
// model checked every cycle, and literal expectations at key points.
module tb_hazard_tracker;

   localparam int TW = 3;
   localparam int RW = 5;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic [TW-1:0] D_tnew = '0;
   logic [RW-1:0] D_A3 = '0;
   logic          D_RFWR = 1'b0;
   logic [RW-1:0] D_rs = '0;
   logic [RW-1:0] D_rt = '0;
   logic          pc_en, d_en, e_clr;
   logic [TW-1:0] E_tnew, M_tnew, W_tnew;
   logic [RW-1:0] E_A3, M_A3, W_A3;
   logic          E_RFWR, M_RFWR, W_RFWR;
   logic [1:0]    fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
   logic          fwd_M_rt;
   logic [CW-1:0] stall_cnt;

   int compared = 0;
   int mismatched = 0;
   bit started = 1'b0;

   hazard_tracker dut (
      .clk(clk), .reset(reset), .stall(stall),
      .D_tnew(D_tnew), .D_A3(D_A3), .D_RFWR(D_RFWR), .D_rs(D_rs), .D_rt(D_rt),
      .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
      .E_tnew(E_tnew), .M_tnew(M_tnew), .W_tnew(W_tnew),
      .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
      .E_RFWR(E_RFWR), .M_RFWR(M_RFWR), .W_RFWR(W_RFWR),
      .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
      .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt),
      .fwd_M_rt(fwd_M_rt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- model: list of in-flight instructions, index 0 = E ----
   typedef struct {
      int tnew;
      int a3;
      int wr;
      int rs;
      int rt;
   } ent_t;

   ent_t pipe [3];
   int   m_cnt = 0;

   function automatic int countdown(int t);
      return (t > 0) ? t - 1 : 0;
   endfunction

   // Code of the youngest stage at or after 'first' that holds r ready.
   function automatic int source_of(int r, int first);
      for (int s = first; s < 3; s++)
         if (r != 0 && pipe[s].wr == 1 && pipe[s].a3 == r && pipe[s].tnew == 0)
            return s + 1;
      return 0;
   endfunction

   always @(posedge clk) begin
      ent_t incoming;
      if (reset) begin
         for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0, 0};
         m_cnt = 0;
      end else begin
         if (stall) begin
            incoming = '{0, 0, 0, 0, 0};
            m_cnt++;
         end else begin
            incoming = '{int'(D_tnew), int'(D_A3), int'(D_RFWR), int'(D_rs), int'(D_rt)};
         end
         // Shift the whole list one stage down, counting tnew toward zero.
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = incoming;
         for (int s = 0; s < 3; s++) pipe[s].tnew = countdown(pipe[s].tnew);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, away from the active edge, compare all outputs with the model.
   always @(negedge clk) begin
      if (started) begin
         chk("pc_en", pc_en, !stall);
         chk("d_en", d_en, !stall);
         chk("e_clr", e_clr, stall);
         chk("E_tnew", E_tnew, pipe[0].tnew);
         chk("M_tnew", M_tnew, pipe[1].tnew);
         chk("W_tnew", W_tnew, pipe[2].tnew);
         chk("E_A3", E_A3, pipe[0].a3);
         chk("M_A3", M_A3, pipe[1].a3);
         chk("W_A3", W_A3, pipe[2].a3);
         chk("E_RFWR", E_RFWR, pipe[0].wr);
         chk("M_RFWR", M_RFWR, pipe[1].wr);
         chk("W_RFWR", W_RFWR, pipe[2].wr);
         chk("fwd_D_rs", fwd_D_rs, source_of(int'(D_rs), 0));
         chk("fwd_D_rt", fwd_D_rt, source_of(int'(D_rt), 0));
         chk("fwd_E_rs", fwd_E_rs, source_of(pipe[0].rs, 1));
         chk("fwd_E_rt", fwd_E_rt, source_of(pipe[0].rt, 1));
         chk("fwd_M_rt", fwd_M_rt, (source_of(pipe[1].rt, 2) == 3) ? 1 : 0);
         chk("stall_cnt", stall_cnt, m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_d(input bit s, input int tn, input int a3, input bit wr,
                        input int rs, input int rt);
      stall  = s;
      D_tnew = TW'(tn);
      D_A3   = RW'(a3);
      D_RFWR = wr;
      D_rs   = RW'(rs);
      D_rt   = RW'(rt);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset with stall low.
      set_d(0, 0, 0, 0, 0, 0);
      tick();
      started = 1'b1;
      tick();
      chk("rst E_tnew", E_tnew, 0);
      chk("rst W_A3", W_A3, 0);
      chk("rst stall_cnt", stall_cnt, 0);
      chk("rst pc_en", pc_en, 1);
      chk("rst fwd_D_rs", fwd_D_rs, 0);
      reset = 1'b0;

      // lui $8, consumer reads rs=8 -> forward from E.
      set_d(0, 1, 8, 1, 0, 0);
      tick();
      set_d(0, 0, 0, 0, 8, 0);
      chk("lui E_tnew", E_tnew, 0);
      chk("lui fwd_D_rs", fwd_D_rs, 1);

      // lw $9 then two stall cycles for a consumer of $9.
      set_d(0, 3, 9, 1, 0, 0);
      tick();
      chk("lw E_tnew", E_tnew, 2);
      set_d(1, 0, 0, 0, 9, 0);
      chk("lw e_clr", e_clr, 1);
      chk("lw pc_en", pc_en, 0);
      tick();
      chk("lw M_tnew", M_tnew, 1);
      chk("lw bubble1 E_A3", E_A3, 0);
      chk("lw notready fwd_D_rs", fwd_D_rs, 0);
      tick();
      chk("lw W_tnew", W_tnew, 0);
      chk("lw bubble2 E_A3", E_A3, 0);
      chk("lw stall_cnt", stall_cnt, 2);
      chk("lw fwd_D_rs", fwd_D_rs, 3);

      // E and M both supply $10.
      set_d(0, 1, 10, 1, 0, 0);
      tick();
      set_d(0, 1, 10, 1, 0, 10);
      tick();
      set_d(0, 0, 0, 0, 0, 10);
      chk("dup fwd_D_rt", fwd_D_rt, 1);
      chk("dup fwd_E_rt", fwd_E_rt, 2);

      // $0 written everywhere, reads of $0 never forward.
      set_d(0, 0, 0, 1, 0, 0);
      tick();
      tick();
      tick();
      chk("zero fwd_D_rs", fwd_D_rs, 0);
      chk("zero fwd_D_rt", fwd_D_rt, 0);
      chk("zero fwd_E_rs", fwd_E_rs, 0);
      chk("zero fwd_M_rt", fwd_M_rt, 0);

      // tnew=0 through all stages; store reading $12 gets it from M then W.
      set_d(0, 0, 12, 1, 0, 0);
      tick();
      set_d(0, 0, 0, 0, 0, 12);
      tick();
      chk("t0 M_tnew", M_tnew, 0);
      chk("t0 fwd_E_rt", fwd_E_rt, 2);
      set_d(0, 0, 0, 0, 0, 0);
      tick();
      chk("t0 W_tnew", W_tnew, 0);
      chk("t0 W_A3", W_A3, 12);
      chk("t0 fwd_M_rt", fwd_M_rt, 1);

      // Reset while W holds $5.
      set_d(0, 0, 5, 1, 0, 0);
      tick();
      set_d(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      set_d(0, 0, 0, 0, 5, 0);
      chk("rst5 W_A3 before", W_A3, 5);
      chk("rst5 fwd_D_rs before", fwd_D_rs, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst5 W_A3", W_A3, 0);
      chk("rst5 W_RFWR", W_RFWR, 0);
      chk("rst5 fwd_D_rs", fwd_D_rs, 0);

      // Mixed traffic on a few registers, checked by the per-cycle model.
      for (int i = 0; i < 60; i++) begin
         set_d(($urandom_range(0, 3) == 0), $urandom_range(0, 4), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
         tick();
      end
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Consumer end of the stall/Tnew handshake in the 5-stage MIPS pipeline.
- Takes the D-stage `stall` request and the D-stage instruction's tnew, A3 and RFWR, and carries them down E/M/W with a per-cycle Tnew countdown.
- Feeds the E/M stage tnew, A3 and RFWR values back to the stall detector.
- Drives pipeline-register enables and the E-stage bubble, and produces forwarding mux selects for the D, E and M stages.

Parameters:
- TNEW_W, 3, width of tnew fields.
- REG_W, 5, register-address width.
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  stall request for the instruction currently in D.
- D_tnew  input  TNEW_W  tnew of the D instruction (cycles until its result exists, counted from D).
- D_A3  input  REG_W  destination register of the D instruction.
- D_RFWR  input  1  D instruction writes the register file.
- D_rs  input  REG_W  rs field of the D instruction.
- D_rt  input  REG_W  rt field of the D instruction.
- pc_en  output  1  PC write enable.
- d_en  output  1  F/D register enable.
- e_clr  output  1  D/E register loads a bubble.
- E_tnew, M_tnew, W_tnew  output  TNEW_W  remaining tnew per stage.
- E_A3, M_A3, W_A3  output  REG_W  destination per stage.
- E_RFWR, M_RFWR, W_RFWR  output  1  write flag per stage.
- fwd_D_rs, fwd_D_rt  output  2  D-read source select: 0=RF, 1=E, 2=M, 3=W.
- fwd_E_rs, fwd_E_rt  output  2  E-read source select: 0=pipe value, 2=M, 3=W.
- fwd_M_rt  output  1  M store data: 0=pipe value, 1=W.
- stall_cnt  output  CNT_W  count of stalled cycles since reset.

Behaviour:
- Registered state: E/M/W copies of tnew, A3, RFWR; E copies of rs and rt; M copy of rt; stall_cnt.
- Reset (sync):
  - All stage registers go to 0, so every stage holds a bubble with RFWR=0 and A3=0.
  - stall_cnt=0.
- Control outputs (combinational):
  - pc_en = d_en = ~stall.
  - e_clr = stall.
  - During reset the outputs follow `stall` unchanged.
- Tnew decrement rule: dec(x) = (x==0) ? 0 : x-1, saturating, never wraps.
- Each rising edge when stall=0:
  - E ← {dec(D_tnew), D_A3, D_RFWR, D_rs, D_rt}.
  - M ← {dec(E_tnew), E_A3, E_RFWR, E_rt}.
  - W ← {dec(M_tnew), M_A3, M_RFWR}.
- Each rising edge when stall=1:
  - E ← bubble (tnew=0, A3=0, RFWR=0, rs=0, rt=0).
  - M and W advance normally; the D instruction is held upstream by d_en=0.
  - stall_cnt increments, wrapping modulo 2^CNT_W.
- A stage "supplies" register r when RFWR=1, A3==r, r!=0 and tnew==0.
- fwd_D_*: priority E > M > W; 0 if no stage supplies the register.
- fwd_E_*: priority M > W, else 0.
- fwd_M_rt: 1 if W supplies M_rt, else 0.
- Register $0 is never forwarded (select 0), whatever A3 or RFWR say.
- A matching stage with tnew>0 is not a source. The stall detector guarantees no consumer needs it, so the select falls through to the older stages.
- All forwarding selects are pure combinational functions of current state plus D_rs/D_rt.
- Reset mid-operation flushes all in-flight entries in one edge; selects read 0 in the next cycle.

Decomposition:
- Shared package (alongside the existing `define` header):
  - TNEW_W and REG_W.
  - FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3.
  - TNEW_NONE=4.
- One natural sub-module: fwd_select. Inputs: read register, per-stage {tnew, A3, RFWR}, stage-enable mask. Output: the priority select. Instantiated 5 times.

Test Plan:
- Reset with stall=0 → all stage outputs 0, stall_cnt=0, pc_en=1, every fwd select 0.
- D: lui (D_tnew=1, A3=8, RFWR=1), next D reads rs=8 → after 1 edge E_tnew=0, fwd_D_rs=1.
- D: lw (D_tnew=3, A3=9), then stall=1 for 2 cycles:
  - E_tnew=2, then M_tnew=1, then W_tnew=0.
  - E shows bubble (E_A3=0) in each stalled cycle.
  - stall_cnt=2.
  - fwd_D_rs=3 once W supplies 9.
- E and M both supply $10 (tnew=0) → fwd_D_rt=1 and fwd_E_rt=2 (newest wins).
- A3=0 with RFWR=1, tnew=0 in every stage, reads rs=rt=0 → all selects 0.
- D_tnew=0 propagated 3 stages → tnew stays 0 (no underflow).
- reset asserted while W holds A3=5 → next cycle W_A3=0, W_RFWR=0, fwd selects 0.
